// File: rtl/sum_requantizer.sv
// Accumulates N_TERMS signed partial sums, then rounds half toward +inf,
// arithmetic-shifts and saturates the total down to OUT_W bits.
module sum_requantizer #(
  parameter int unsigned IN_W    = 18,
  parameter int unsigned OUT_W   = 17,
  parameter int unsigned N_TERMS = 10,
  parameter int unsigned ACC_W   = 24,
  parameter int unsigned SHIFT   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);

  localparam int unsigned CNT_W  = (N_TERMS > 1) ? $clog2(N_TERMS) : 1;
  localparam int unsigned CALC_W = ACC_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_TERMS - 1);
  localparam logic signed [CALC_W-1:0] RND = CALC_W'((2 ** SHIFT) / 2);
  localparam logic signed [CALC_W-1:0] SAT_MAX =
    {{(CALC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CALC_W-1:0] SAT_MIN =
    {{(CALC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {ACC, CALC, HOLD} state_t;

  state_t                   state, state_d;
  logic signed [ACC_W-1:0]  acc, acc_d;
  logic [CNT_W-1:0]         cnt, cnt_d;
  logic                     in_ready_d, out_valid_d, out_sat_d;
  logic signed [OUT_W-1:0]  out_data_d;
  logic signed [ACC_W-1:0]  in_ext_c;
  logic signed [CALC_W-1:0] rnd_sum_c, shifted_c;

  // One guard bit above the accumulator keeps the rounding add from wrapping
  assign in_ext_c  = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign rnd_sum_c = {acc[ACC_W-1], acc} + RND;
  assign shifted_c = rnd_sum_c >>> SHIFT;

  // State and all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      cnt       <= cnt_d;
      in_ready  <= in_ready_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_sat   <= out_sat_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state;
    acc_d       = acc;
    cnt_d       = cnt;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_sat_d   = out_sat;
    case (state)
      ACC: begin
        if (in_valid && in_ready) begin
          acc_d = acc + in_ext_c;
          if (cnt == LAST_CNT) begin
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            cnt_d = cnt + CNT_W'(1);
          end
        end
      end
      CALC: begin
        out_valid_d = 1'b1;
        state_d     = HOLD;
        if (shifted_c > SAT_MAX) begin
          out_data_d = SAT_MAX[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else if (shifted_c < SAT_MIN) begin
          out_data_d = SAT_MIN[OUT_W-1:0];
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = shifted_c[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
      end
      HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase
    in_ready_d = (state_d == ACC);
  end

endmodule

// File: tb/tb_sum_requantizer.sv
// Self-checking bench: one instance with N_TERMS=4/SHIFT=1, one with N_TERMS=1/SHIFT=0.
module tb_sum_requantizer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic               in_valid, in_ready, out_valid, out_ready, out_sat;
  logic signed [17:0] in_data;
  logic signed [16:0] out_data;

  logic               in_valid1, in_ready1, out_valid1, out_ready1, out_sat1;
  logic signed [17:0] in_data1;
  logic signed [16:0] out_data1;

  sum_requantizer #(.IN_W(18), .OUT_W(17), .N_TERMS(4), .ACC_W(24), .SHIFT(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat));

  sum_requantizer #(.IN_W(18), .OUT_W(17), .N_TERMS(1), .ACC_W(24), .SHIFT(0)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1), .out_sat(out_sat1));

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int terms[4];
    int exp_data;
    int exp_sat;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model of one group: sum, round half toward +inf at SHIFT=1, clamp to 17 bits
  function automatic void model(input longint sum, output longint d, output longint s);
    longint x;
    x = sum + 1;
    if (x >= 0) d = x / 2;
    else d = -((-x + 1) / 2);
    s = 0;
    if (d > 65535) begin d = 65535; s = 1; end
    if (d < -65536) begin d = -65536; s = 1; end
  endfunction

  task automatic push(input int v, input int gap);
    int n = 0;
    repeat (gap) begin @(posedge clk); #1; end
    in_valid = 1'b1;
    in_data  = 18'(v);
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("push_timeout", 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic get_result(input int delay, output longint d, output longint s);
    int n = 0;
    repeat (delay) begin @(posedge clk); #1; end
    out_ready = 1'b1;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("result_timeout", 0, 1);
    d = out_data;
    s = out_sat;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic push1(input int v, output int tcyc);
    int n = 0;
    in_valid1 = 1'b1;
    in_data1  = 18'(v);
    while (!in_ready1 && n < 50) begin @(posedge clk); #1; n++; end
    if (n >= 50) chk("push1_timeout", 0, 1);
    @(posedge clk); #1;
    tcyc = cyc;
    in_valid1 = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    longint d, s, ed, es, sum;
    int vals[4];
    int t_prev, t_now;
    int exp1_d[3];
    int exp1_s[3];
    int in1[3];

    vecs[0] = '{terms: '{100, 200, -50, 1},               exp_data: 126,    exp_sat: 0};
    vecs[1] = '{terms: '{-1, -1, -1, 0},                  exp_data: -1,     exp_sat: 0};
    vecs[2] = '{terms: '{131071, 131071, 131071, 131071}, exp_data: 65535,  exp_sat: 1};
    vecs[3] = '{terms: '{-131072, -131072, -131072, -131072}, exp_data: -65536, exp_sat: 1};
    vecs[4] = '{terms: '{131070, 0, 0, 0},                exp_data: 65535,  exp_sat: 0};
    vecs[5] = '{terms: '{131071, 0, 0, 0},                exp_data: 65535,  exp_sat: 1};
    vecs[6] = '{terms: '{-131072, 0, 0, 0},               exp_data: -65536, exp_sat: 0};
    vecs[7] = '{terms: '{-131074, 0, 0, 0},               exp_data: -65536, exp_sat: 1};
    // -131074 is outside 18 bits; split it across two terms
    vecs[7].terms[0] = -131072;
    vecs[7].terms[1] = -2;

    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid1 = 1'b0; in_data1 = '0; out_ready1 = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", in_ready, 1);

    // Table vectors, with latency check on each group
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < 4; k++) push(vecs[i].terms[k], 0);
      chk($sformatf("v%0d_calc_not_valid", i), out_valid, 0);
      chk($sformatf("v%0d_calc_in_ready", i), in_ready, 0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid_latency", i), out_valid, 1);
      get_result(0, d, s);
      chk($sformatf("v%0d_data", i), d, vecs[i].exp_data);
      chk($sformatf("v%0d_sat", i), s, vecs[i].exp_sat);
    end

    // Idle gaps between terms
    push(100, 3); push(200, 2); push(-50, 1); push(1, 4);
    get_result(0, d, s);
    chk("gap_data", d, 126);
    chk("gap_sat", s, 0);

    // Backpressure: result held, input blocked until after the handshake
    push(3, 0); push(5, 0); push(7, 0); push(9, 0);
    begin
      int n = 0;
      while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    end
    chk("bp_data", out_data, 12);
    chk("bp_sat", out_sat, 0);
    in_valid = 1'b1; in_data = 18'(1000);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_valid_c%0d", c), out_valid, 1);
      chk($sformatf("bp_hold_c%0d", c), out_data, 12);
      chk($sformatf("bp_sathold_c%0d", c), out_sat, 0);
      chk($sformatf("bp_in_ready_c%0d", c), in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp_valid_dropped", out_valid, 0);
    chk("bp_in_ready_back", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    push(0, 0); push(0, 0); push(0, 0);
    get_result(0, d, s);
    chk("bp_next_group", d, 500);

    // Reset mid-accumulation
    push(7, 0); push(9, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_data", out_data, 0);
    for (int k = 0; k < 4; k++) push(10, 0);
    get_result(0, d, s);
    chk("midrst_data", d, 20);
    chk("midrst_sat", s, 0);

    // Randomized groups against the model
    for (int g = 0; g < 40; g++) begin
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 1) == 1) vals[k] = int'($urandom_range(0, 262143)) - 131072;
        else vals[k] = int'($urandom_range(0, 2000)) - 1000;
        sum += vals[k];
        push(vals[k], int'($urandom_range(0, 2)));
      end
      model(sum, ed, es);
      get_result(int'($urandom_range(0, 3)), d, s);
      chk($sformatf("rnd%0d_data", g), d, ed);
      chk($sformatf("rnd%0d_sat", g), s, es);
    end

    // N_TERMS=1, SHIFT=0 back-to-back stream
    in1 = '{5, -7, 65536};
    exp1_d = '{5, -7, 65535};
    exp1_s = '{0, 0, 1};
    t_prev = 0;
    for (int i = 0; i < 3; i++) begin
      int n = 0;
      push1(in1[i], t_now);
      while (!out_valid1 && n < 50) begin @(posedge clk); #1; n++; end
      chk($sformatf("b2b%0d_valid", i), out_valid1, 1);
      chk($sformatf("b2b%0d_data", i), out_data1, exp1_d[i]);
      chk($sformatf("b2b%0d_sat", i), out_sat1, exp1_s[i]);
      if (i > 0) chk($sformatf("b2b%0d_period", i), t_now - t_prev, 3);
      t_prev = t_now;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
